snoop_bus_arbiter: RTL and testbench
====================================

# snoop_bus_arbiter

Initiator side of the coherency snoop bus. Accepts bus-read and bus-write requests from N cache controllers and arbitrates among them round-robin. Drives the winning transaction onto the shared `bus` word (a `bus_prefix_t` prefix from `set.vh` plus the line address) that every `set` instance snoops. Sits between the per-core cache controllers and the broadcast snoop bus; it is the only driver of `bus`.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, line address width; must match the snooping sets.
- `N`, 2, number of requesting cache controllers; ≥1.
- `HOLD_CYCLES`, 1, number of cycles each transaction is held on `bus`; ≥1.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, no new transaction starts; an in-flight one completes.
- `req`  in  N  per-requester request level; held high until its `done`.
- `req_wr`  in  N  per-requester kind: 0 = `E_BUS_RD`, 1 = `E_BUS_WR`.
- `req_addr`  in  N*ADDR_WIDTH  flattened addresses; requester i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `grant`  out  N  one-hot; high for the whole time requester i's transaction is on `bus`.
- `done`  out  N  one-hot, one-cycle pulse on the last hold cycle.
- `busy`  out  1  high while in DRIVE.
- `bus`  out  `$bits(bus_prefix_t)+ADDR_WIDTH`  prefix in the upper bits (`ev` field), address in `[ADDR_WIDTH-1:0]`.

## Operation
- States: IDLE, DRIVE. Registers: `rr_ptr` (width `max(1,$clog2(N))`), `owner`, `hold_cnt` (width `$clog2(HOLD_CYCLES+1)`).
- IDLE: `bus.ev = E_NOTHING`, address 0, `grant`=0, `done`=0, `busy`=0.
- IDLE, `enable`=1, any `req` high: select the first index i with `req[i]`, scanning from `rr_ptr` upward modulo N.
  - Latch `owner`=i.
  - Drive `bus` = {`req_wr[i]` ? `E_BUS_WR` : `E_BUS_RD`, `req_addr[i]`}.
  - Set `grant[i]`, `busy`; `hold_cnt`=1; go to DRIVE.
- DRIVE: `bus` and `grant` stay constant; `req_*` inputs are ignored after they are latched.
  - `hold_cnt`<`HOLD_CYCLES`: increment.
  - `hold_cnt`==`HOLD_CYCLES`: `done[owner]` is high this cycle. At the next edge: go to IDLE, clear `bus`/`grant`/`busy`, `rr_ptr` = `owner`+1 mod N.
- A `req` dropped mid-DRIVE does not abort the transaction; `done` still pulses.
- `enable` low in DRIVE has no effect.
- `E_PR_RD`/`E_PR_WR` are never driven; those events stay core-local.
- N=1: `rr_ptr` is constant 0.

## Timing
- All outputs are registered. Reset (async, `reset_n`=0): `bus`=`{E_NOTHING,0}`, `grant`=0, `done`=0, `busy`=0, state IDLE, `rr_ptr`=0, `hold_cnt`=0. A reset mid-DRIVE drops the transaction immediately.
- Request sampled at edge E: `bus`/`grant` are valid from E up to edge E+HOLD_CYCLES. `done` is high in the cycle before E+HOLD_CYCLES.
- The requester samples `done` at E+HOLD_CYCLES and drops `req` at that edge. A `req` still high at the next IDLE edge is a new request.
- At least one `E_NOTHING` cycle separates consecutive transactions. Back-to-back throughput is one transaction per HOLD_CYCLES+1 cycles.
- Requests that arrive simultaneously are resolved purely by `rr_ptr`. No requester waits more than N-1 transactions.

## Configuration
- `SNOOP_BUS_STATS_EN` defined:
  - Adds output `bus_txn_count` (32 bits). It resets to 0 and increments at each `done` edge, wrapping at 2^32.
  - Adds output `bus_wr_count` (32 bits), which counts `E_BUS_WR` transactions only.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Single request: N=2, HOLD_CYCLES=1, `req[0]`=1, `req_wr[0]`=0, addr 8'h3C.
  - Next cycle `bus`={`E_BUS_RD`,8'h3C}, `grant`=2'b01, `done`=2'b01 for one cycle.
  - Following cycle `bus.ev`=`E_NOTHING`.
- Contention: `req`=2'b11 held continuously from reset.
  - Grants alternate 01,10,01,10, each separated by one `E_NOTHING` cycle.
  - `bus.ev`/address follow each owner's `req_wr`/`req_addr`.
- HOLD_CYCLES=3, write to 8'hA5:
  - `bus`={`E_BUS_WR`,8'hA5} stable for 3 cycles.
  - `done` is high only in the third cycle; `busy` is high for all 3.
- Abort/enable:
  - `req[1]` dropped in the first DRIVE cycle → transaction still completes with `done`=2'b10.
  - `enable`=0 while in IDLE with `req`=2'b01 → no grant until `enable` returns to 1.
- Reset mid-DRIVE: `reset_n`=0 asynchronously → `bus`=`{E_NOTHING,0}`, `grant`=0 immediately. After release, the first grant goes to requester 0.
- With `SNOOP_BUS_STATS_EN`: 5 transactions, 2 of them writes → `bus_txn_count`=5, `bus_wr_count`=2. Both read 0 after reset.

Source files
------------

// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snoop_bus_arbiter                                                          |
// | Round-robin initiator of the coherency snoop bus; optional statistics      |
// | counters are enabled with the SNOOP_BUS_STATS_EN macro.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

// Snoop-bus prefix layout, matching what the snooping sets expect from set.vh.
package snoop_bus_pkg;
    typedef enum logic [2:0] {
        E_NOTHING = 3'd0,
        E_PR_RD   = 3'd1,
        E_PR_WR   = 3'd2,
        E_BUS_RD  = 3'd3,
        E_BUS_WR  = 3'd4
    } bus_event_t;

    typedef struct packed {
        bus_event_t ev;
    } bus_prefix_t;
endpackage

module snoop_bus_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int N           = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic [N-1:0]                           req,
    input  logic [N-1:0]                           req_wr,
    input  logic [N*ADDR_WIDTH-1:0]                req_addr,
    output logic [N-1:0]                           grant,
    output logic [N-1:0]                           done,
    output logic                                   busy,
`ifdef SNOOP_BUS_STATS_EN
    output logic [31:0]                            bus_txn_count,
    output logic [31:0]                            bus_wr_count,
`endif
    output logic [$bits(bus_prefix_t)+ADDR_WIDTH-1:0] bus
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int BUS_W = $bits(bus_prefix_t) + ADDR_WIDTH;
    localparam logic [BUS_W-1:0] BUS_IDLE = {E_NOTHING, {ADDR_WIDTH{1'b0}}};

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRIVE = 1'b1;

    logic [0:0]            state;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      owner;
    logic [CNT_W-1:0]      hold_cnt;

    logic [PTR_W:0]        cand;
    logic [PTR_W-1:0]      pick;
    logic [N-1:0]          pick_oh;
    bus_prefix_t           pick_pfx;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [PTR_W:0]        next_ptr;
    logic                  last_hold;

    // Scanning from the highest offset down leaves the first hit after rr_ptr.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N)) begin
                cand = cand - (PTR_W+1)'(N);
            end
            if (req[cand[PTR_W-1:0]]) begin
                pick = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        pick_oh = '0;
        for (int i = 0; i < N; i++) begin
            pick_oh[i] = (pick == PTR_W'(i));
        end
    end

    always_comb begin
        pick_pfx.ev = req_wr[pick] ? E_BUS_WR : E_BUS_RD;
        pick_addr   = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
        next_ptr    = {1'b0, owner} + (PTR_W+1)'(1);
        if (next_ptr == (PTR_W+1)'(N)) begin
            next_ptr = '0;
        end
        last_hold = (hold_cnt == CNT_W'(HOLD_CYCLES));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
            bus      <= BUS_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable && (|req)) begin
                        state    <= S_DRIVE;
                        owner    <= pick;
                        hold_cnt <= CNT_W'(1);
                        grant    <= pick_oh;
                        busy     <= 1'b1;
                        done     <= (HOLD_CYCLES == 1) ? pick_oh : '0;
                        bus      <= {pick_pfx, pick_addr};
                    end
                end
                default: begin
                    if (last_hold) begin
                        state    <= S_IDLE;
                        hold_cnt <= '0;
                        grant    <= '0;
                        done     <= '0;
                        busy     <= 1'b0;
                        bus      <= BUS_IDLE;
                        rr_ptr   <= next_ptr[PTR_W-1:0];
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                        // done is registered, so raise it one edge ahead of the last hold cycle
                        done     <= (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) ? grant : '0;
                    end
                end
            endcase
        end
    end

`ifdef SNOOP_BUS_STATS_EN
    bus_prefix_t cur_pfx;
    assign cur_pfx = bus[BUS_W-1:ADDR_WIDTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus_txn_count <= '0;
            bus_wr_count  <= '0;
        end else if (state == S_DRIVE && last_hold) begin
            bus_txn_count <= bus_txn_count + 32'd1;
            if (cur_pfx.ev == E_BUS_WR) begin
                bus_wr_count <= bus_wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_snoop_bus_arbiter                                                       |
// | Self-checking bench: two arbiter instances against a transaction model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_snoop_bus_arbiter;
    import snoop_bus_pkg::*;

    localparam int AW = 8;
    localparam int PW = $bits(bus_prefix_t);
    localparam int BW = PW + AW;
    localparam logic [BW-1:0] BUS_IDLE = {E_NOTHING, 8'h00};

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // Instance a: N=2, HOLD_CYCLES=1.  Instance b: N=3, HOLD_CYCLES=3.
    logic          en_a, en_b;
    logic [1:0]    req_a, wr_a, grant_a, done_a;
    logic [2:0]    req_b, wr_b, grant_b, done_b;
    logic [2*AW-1:0] addr_a;
    logic [3*AW-1:0] addr_b;
    logic          busy_a, busy_b;
    logic [BW-1:0] bus_a, bus_b;
`ifdef SNOOP_BUS_STATS_EN
    logic [31:0]   txn_a, wrc_a, txn_b, wrc_b;
`endif

    snoop_bus_arbiter #(.ADDR_WIDTH(AW), .N(2), .HOLD_CYCLES(1)) u_a (
        .clock(clock), .reset_n(reset_n), .enable(en_a),
        .req(req_a), .req_wr(wr_a), .req_addr(addr_a),
        .grant(grant_a), .done(done_a), .busy(busy_a),
`ifdef SNOOP_BUS_STATS_EN
        .bus_txn_count(txn_a), .bus_wr_count(wrc_a),
`endif
        .bus(bus_a)
    );

    snoop_bus_arbiter #(.ADDR_WIDTH(AW), .N(3), .HOLD_CYCLES(3)) u_b (
        .clock(clock), .reset_n(reset_n), .enable(en_b),
        .req(req_b), .req_wr(wr_b), .req_addr(addr_b),
        .grant(grant_b), .done(done_b), .busy(busy_b),
`ifdef SNOOP_BUS_STATS_EN
        .bus_txn_count(txn_b), .bus_wr_count(wrc_b),
`endif
        .bus(bus_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: remaining cycles of the current transaction per instance.
    int            m_rr[2];
    int            m_owner[2];
    int            m_rem[2];
    logic [BW-1:0] m_bus[2];
    logic [31:0]   m_txn[2];
    logic [31:0]   m_wrs[2];

    function automatic int n_of(input int u);
        return (u == 0) ? 2 : 3;
    endfunction

    function automatic int h_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic logic req_of(input int u, input int i);
        return (u == 0) ? req_a[i] : req_b[i];
    endfunction

    function automatic logic [BW-1:0] word_of(input int u, input int i);
        logic          w;
        logic [AW-1:0] a;
        if (u == 0) begin
            w = wr_a[i];
            a = addr_a[i*AW +: AW];
        end else begin
            w = wr_b[i];
            a = addr_b[i*AW +: AW];
        end
        return {(w ? E_BUS_WR : E_BUS_RD), a};
    endfunction

    function automatic logic [2:0] exp_grant(input int u);
        return (m_rem[u] > 0) ? 3'(1 << m_owner[u]) : 3'b000;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_rr[u]    = 0;
            m_owner[u] = 0;
            m_rem[u]   = 0;
            m_bus[u]   = BUS_IDLE;
            m_txn[u]   = 32'd0;
            m_wrs[u]   = 32'd0;
        end
    endtask

    task automatic model_edge(input int u);
        int i;
        if (reset_n) begin
            if (m_rem[u] > 0) begin
                m_rem[u] = m_rem[u] - 1;
                if (m_rem[u] == 0) begin
                    m_txn[u] = m_txn[u] + 32'd1;
                    if (m_bus[u][BW-1 -: PW] == E_BUS_WR) m_wrs[u] = m_wrs[u] + 32'd1;
                    m_rr[u]  = (m_owner[u] + 1) % n_of(u);
                    m_bus[u] = BUS_IDLE;
                end
            end else if ((u == 0) ? en_a : en_b) begin
                for (int k = 0; k < n_of(u); k++) begin
                    i = (m_rr[u] + k) % n_of(u);
                    if (m_rem[u] == 0 && req_of(u, i)) begin
                        m_owner[u] = i;
                        m_rem[u]   = h_of(u);
                        m_bus[u]   = word_of(u, i);
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a.bus",   32'(bus_a),   32'(m_bus[0]));
        chk("a.grant", 32'(grant_a), 32'(exp_grant(0)));
        chk("a.done",  32'(done_a),  (m_rem[0] == 1) ? 32'(exp_grant(0)) : 32'd0);
        chk("a.busy",  32'(busy_a),  32'(m_rem[0] > 0));
        chk("b.bus",   32'(bus_b),   32'(m_bus[1]));
        chk("b.grant", 32'(grant_b), 32'(exp_grant(1)));
        chk("b.done",  32'(done_b),  (m_rem[1] == 1) ? 32'(exp_grant(1)) : 32'd0);
        chk("b.busy",  32'(busy_b),  32'(m_rem[1] > 0));
`ifdef SNOOP_BUS_STATS_EN
        chk("a.txn_count", txn_a, m_txn[0]);
        chk("a.wr_count",  wrc_a, m_wrs[0]);
        chk("b.txn_count", txn_b, m_txn[1]);
        chk("b.wr_count",  wrc_b, m_wrs[1]);
`endif
    endtask

    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        logic [BW-1:0] want;
        logic [1:0]    cont_exp [8];

        en_a = 1'b1; en_b = 1'b1;
        req_a = '0; wr_a = '0; addr_a = '0;
        req_b = '0; wr_b = '0; addr_b = '0;
        model_reset();
        #1;
        check_all();
        @(posedge clock); #1;
        check_all();
        reset_n = 1'b1;

        // Single read request to 8'h3C
        req_a = 2'b01; wr_a = 2'b00; addr_a = {8'h00, 8'h3C};
        step();
        want = {E_BUS_RD, 8'h3C};
        chk("single.bus",   32'(bus_a),   32'(want));
        chk("single.grant", 32'(grant_a), 32'd1);
        chk("single.done",  32'(done_a),  32'd1);
        req_a = 2'b00;
        step();
        chk("single.idle_ev", 32'(bus_a[BW-1 -: PW]), 32'(E_NOTHING));

        // Contention: rr pointer now favours requester 1
        cont_exp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        req_a = 2'b11; wr_a = 2'b10; addr_a = {8'h22, 8'h11};
        for (int k = 0; k < 8; k++) begin
            step();
            chk("cont.grant", 32'(grant_a), 32'(cont_exp[k]));
            if (k == 0) begin
                want = {E_BUS_WR, 8'h22};
                chk("cont.bus", 32'(bus_a), 32'(want));
            end
        end
        req_a = 2'b00;
        step();

        // Three-cycle write hold on instance b
        req_b = 3'b100; wr_b = 3'b100; addr_b = {8'hA5, 8'h00, 8'h00};
        want = {E_BUS_WR, 8'hA5};
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold3.bus",  32'(bus_b),  32'(want));
            chk("hold3.busy", 32'(busy_b), 32'd1);
            chk("hold3.done", 32'(done_b), (k == 2) ? 32'd4 : 32'd0);
        end
        req_b = 3'b000;
        step();
        chk("hold3.after", 32'(busy_b), 32'd0);

        // Request dropped during the transaction still completes
        req_b = 3'b010; wr_b = 3'b000; addr_b = {8'h00, 8'h5A, 8'h00};
        step();
        req_b = 3'b000;
        step();
        step();
        chk("abort.done", 32'(done_b), 32'd2);
        step();

        // enable low holds off a new grant
        en_a = 1'b0; req_a = 2'b01;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("enable.off", 32'(grant_a), 32'd0);
        end
        en_a = 1'b1;
        step();
        chk("enable.on", 32'(grant_a), 32'd1);
        req_a = 2'b00;
        step();

        // Asynchronous reset in the middle of a transaction
        req_a = 2'b11; req_b = 3'b001;
        step();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst.bus",   32'(bus_a),   32'(BUS_IDLE));
        chk("rst.grant", 32'(grant_b), 32'd0);
        @(posedge clock); #1;
        check_all();
        reset_n = 1'b1;
        step();
        chk("rst.first", 32'(grant_a), 32'd1);
        req_a = 2'b00; req_b = 3'b000;
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            req_a  = 2'($urandom_range(0, 3));
            wr_a   = 2'($urandom_range(0, 3));
            addr_a = 16'($urandom);
            en_a   = ($urandom_range(0, 7) != 0);
            req_b  = 3'($urandom_range(0, 7));
            wr_b   = 3'($urandom_range(0, 7));
            addr_b = 24'($urandom);
            en_b   = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
